// File: rtl/vector_pkg.sv
// Shared vector display-list types: ROM entry layout, coordinate width and walker states.
// Used by every shape ROM, the walker and the DAC stage.
package vector_pkg;

  localparam int COORD_W = 8;
  localparam int SCNT_W  = 4;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               draw;
    logic               move;
  } vec_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SETTLE_S,
    DRAW,
    DONE
  } walker_state_t;

  function automatic logic is_end(vec_entry_t e);
    return !e.draw && !e.move;
  endfunction

endpackage

// File: rtl/line_stepper.sv
// Integer Bresenham engine: load a segment, then each step cycle presents the next
// beam position on x/y and flags the step that lands on the target.
module line_stepper
  import vector_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  logic [COORD_W-1:0] cx, cy, tx, ty, dx, dy;
  logic               sx, sy;
  logic signed [9:0]  err, err_nxt, dx10, dy10;
  logic signed [10:0] e2, dxw, dyw;
  logic               stepx, stepy;
  logic [COORD_W-1:0] dxl, dyl;

  assign dxl = (x1 >= x0) ? x1 - x0 : x0 - x1;
  assign dyl = (y1 >= y0) ? y1 - y0 : y0 - y1;

  // err itself stays inside 10 bits, but 2*err can exceed it on shallow
  // lines (dx=255, dy=1 reaches err=381), so the doubled term gets one more bit.
  always_comb begin
    dx10    = {2'b00, dx};
    dy10    = {2'b00, dy};
    dxw     = {3'b000, dx};
    dyw     = {3'b000, dy};
    e2      = {err[9], err} <<< 1;
    stepx   = e2 > -dyw;
    stepy   = e2 < dxw;
    err_nxt = err - (stepx ? dy10 : 10'sd0) + (stepy ? dx10 : 10'sd0);
    x       = stepx ? (sx ? cx - COORD_W'(1) : cx + COORD_W'(1)) : cx;
    y       = stepy ? (sy ? cy - COORD_W'(1) : cy + COORD_W'(1)) : cy;
    last    = (x == tx) && (y == ty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cx  <= '0;
      cy  <= '0;
      tx  <= '0;
      ty  <= '0;
      dx  <= '0;
      dy  <= '0;
      sx  <= 1'b0;
      sy  <= 1'b0;
      err <= '0;
    end else if (load) begin
      cx  <= x0;
      cy  <= y0;
      tx  <= x1;
      ty  <= y1;
      dx  <= dxl;
      dy  <= dyl;
      sx  <= x1 < x0;
      sy  <= y1 < y0;
      err <= 10'(dxl) - 10'(dyl);
    end else if (step) begin
      cx  <= x;
      cy  <= y;
      err <= err_nxt;
    end
  end

endmodule

// File: rtl/vector_walker.sv
// Walks a zero-latency shape ROM and produces a per-cycle X/Y beam trajectory:
// blanked jumps with settle dwell on moves, lit Bresenham lines on draws.
module vector_walker
  import vector_pkg::*;
#(
  parameter int ADDRESSWIDTH = 4,
  parameter int DATAWIDTH    = 18,
  parameter int NUM_ENTRIES  = 16,
  parameter int SETTLE       = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [ADDRESSWIDTH-1:0] rom_addr,
  input  logic [DATAWIDTH-1:0]    rom_data,
  output logic [COORD_W-1:0]      x_out,
  output logic [COORD_W-1:0]      y_out,
  output logic                    beam_on,
  output logic                    busy,
  output logic                    done
);

  localparam logic [ADDRESSWIDTH-1:0] LAST_ADDR = ADDRESSWIDTH'(NUM_ENTRIES - 1);

  walker_state_t      state, state_n;
  logic [SCNT_W-1:0]  scnt, scnt_n;
  vec_entry_t         ent;
  logic               adv, clr, ld, stp, jump, at_end;
  logic [COORD_W-1:0] st_x, st_y;
  logic               st_last;

  assign ent    = vec_entry_t'(rom_data);
  assign at_end = rom_addr == LAST_ADDR;

  line_stepper u_line (
    .clk  (clk),
    .rst  (rst),
    .load (ld),
    .step (stp),
    .x0   (x_out),
    .y0   (y_out),
    .x1   (ent.x),
    .y1   (ent.y),
    .x    (st_x),
    .y    (st_y),
    .last (st_last)
  );

  always_comb begin
    state_n = state;
    scnt_n  = scnt;
    adv     = 1'b0;
    clr     = 1'b0;
    ld      = 1'b0;
    stp     = 1'b0;
    jump    = 1'b0;
    case (state)
      IDLE: if (start) begin
        clr     = 1'b1;
        state_n = FETCH;
      end
      FETCH: begin
        if (is_end(ent)) begin
          state_n = DONE;
        end else if (ent.move) begin
          jump    = 1'b1;
          scnt_n  = SCNT_W'(SETTLE);
          state_n = SETTLE_S;
        end else if (ent.x == x_out && ent.y == y_out) begin
          adv = 1'b1;
        end else begin
          ld      = 1'b1;
          state_n = DRAW;
        end
      end
      SETTLE_S: begin
        scnt_n = scnt - SCNT_W'(1);
        adv    = scnt == SCNT_W'(1);
      end
      DRAW: begin
        stp = 1'b1;
        adv = st_last;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Consuming the last address ends the list; the address never wraps.
    if (adv) state_n = at_end ? DONE : FETCH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      scnt     <= '0;
      rom_addr <= '0;
      x_out    <= '0;
      y_out    <= '0;
    end else begin
      state <= state_n;
      scnt  <= scnt_n;
      if (clr)                rom_addr <= '0;
      else if (adv && !at_end) rom_addr <= rom_addr + ADDRESSWIDTH'(1);
      if (jump) begin
        x_out <= ent.x;
        y_out <= ent.y;
      end else if (stp) begin
        x_out <= st_x;
        y_out <= st_y;
      end
    end
  end

  assign beam_on = state == DRAW;
  assign busy    = (state == FETCH) || (state == SETTLE_S) || (state == DRAW);
  assign done    = state == DONE;

endmodule

// File: tb/tb_vector_walker.sv
// Self-checking bench: directed lists plus random lists, compared cycle by cycle
// against a sequential trace model of the display-list walk.
module tb_vector_walker;

  localparam int AW = 4;
  localparam int DW = 18;
  localparam int NE = 16;
  localparam int ST = 4;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [7:0]    x_out, y_out;
  logic          beam_on, busy, done;
  logic [DW-1:0] rom [NE];

  assign rom_data = rom[rom_addr];

  vector_walker #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .NUM_ENTRIES(NE), .SETTLE(ST)) dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .x_out(x_out), .y_out(y_out), .beam_on(beam_on), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int npass = 0;
  int mx, my;
  logic [22:0] exp_q[$];
  int obs_busy, obs_lit, obs_xch, obs_ych, obs_done, obs_maxstep, done_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    nchk++;
    if (got === want) npass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  function automatic logic [17:0] ent(input int x, input int y, input bit d, input bit m);
    return {x[7:0], y[7:0], d, m};
  endfunction

  function automatic logic [22:0] pk(input int a, input int x, input int y,
                                     input bit b, input bit bs, input bit dn);
    return {a[3:0], x[7:0], y[7:0], b, bs, dn};
  endfunction

  // Expected visible outputs for each cycle from the first FETCH through DONE.
  task automatic model_walk();
    int a, tx, ty, dx, dy, sx, sy, err, e2;
    bit fin;
    logic [17:0] e;
    exp_q.delete();
    a = 0;
    fin = 0;
    while (!fin) begin
      e  = rom[a];
      tx = int'(e[17:10]);
      ty = int'(e[9:2]);
      exp_q.push_back(pk(a, mx, my, 0, 1, 0));
      if (e[1:0] == 2'b00) begin
        fin = 1;
      end else begin
        if (e[0]) begin
          mx = tx;
          my = ty;
          repeat (ST) exp_q.push_back(pk(a, mx, my, 0, 1, 0));
        end else begin
          dx  = (tx > mx) ? tx - mx : mx - tx;
          dy  = (ty > my) ? ty - my : my - ty;
          sx  = (tx > mx) ? 1 : -1;
          sy  = (ty > my) ? 1 : -1;
          err = dx - dy;
          while (mx != tx || my != ty) begin
            exp_q.push_back(pk(a, mx, my, 1, 1, 0));
            e2 = 2 * err;
            if (e2 > -dy) begin err -= dy; mx += sx; end
            if (e2 < dx)  begin err += dx; my += sy; end
          end
        end
        if (a == NE - 1) fin = 1;
        else a++;
      end
    end
    exp_q.push_back(pk(a, mx, my, 0, 0, 1));
  endtask

  task automatic run_walk(input bit noise);
    int px, py, pb, d;
    logic [22:0] last_exp;
    model_walk();
    obs_busy = 0; obs_lit = 0; obs_xch = 0; obs_ych = 0; obs_done = 0;
    obs_maxstep = 0; done_addr = -1; pb = 0; px = 0; py = 0;
    start = 1'b1;
    foreach (exp_q[i]) begin
      @(posedge clk); #1;
      start = noise && ($urandom_range(0, 3) == 0);
      chk("trace", {9'd0, rom_addr, x_out, y_out, beam_on, busy, done}, {9'd0, exp_q[i]});
      if (busy) obs_busy++;
      if (beam_on) obs_lit++;
      if (pb != 0) begin
        if (int'(x_out) != px) obs_xch++;
        if (int'(y_out) != py) obs_ych++;
        d = (int'(x_out) > px) ? int'(x_out) - px : px - int'(x_out);
        if (d > obs_maxstep) obs_maxstep = d;
        d = (int'(y_out) > py) ? int'(y_out) - py : py - int'(y_out);
        if (d > obs_maxstep) obs_maxstep = d;
      end
      if (done) begin obs_done++; done_addr = int'(rom_addr); end
      pb = int'(beam_on); px = int'(x_out); py = int'(y_out);
    end
    last_exp = exp_q[$];
    @(posedge clk); #1;
    start = 1'b0;
    chk("idle_after", {25'd0, rom_addr, beam_on, busy, done}, {25'd0, last_exp[22:19], 3'b000});
  endtask

  task automatic clear_rom();
    for (int i = 0; i < NE; i++) rom[i] = '0;
  endtask

  initial begin
    int f, prevx, prevy;
    rst = 1'b1;
    start = 1'b0;
    clear_rom();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", {28'd0, rom_addr}, 0);
    chk("rst_xy", {16'd0, x_out, y_out}, 0);
    chk("rst_flags", {29'd0, beam_on, busy, done}, 0);
    rst = 1'b0;
    mx = 0; my = 0;

    // move then draw
    clear_rom();
    rom[0] = ent(174, 162, 0, 1);
    rom[1] = ent(161, 147, 1, 0);
    run_walk(1);
    chk("mv_busy", obs_busy, 22);
    chk("mv_lit", obs_lit, 15);
    chk("mv_end", {16'd0, x_out, y_out}, {16'd0, 8'd161, 8'd147});
    chk("mv_done", obs_done, 1);

    // line shape (0,0)->(10,3)
    clear_rom();
    rom[0] = ent(0, 0, 0, 1);
    rom[1] = ent(10, 3, 1, 0);
    run_walk(0);
    chk("ln_lit", obs_lit, 10);
    chk("ln_xch", obs_xch, 10);
    chk("ln_ych", obs_ych, 3);
    chk("ln_step", obs_maxstep, 1);
    chk("ln_end", {16'd0, x_out, y_out}, {16'd0, 8'd10, 8'd3});

    // both flags acts as move; zero-length draw costs one FETCH
    clear_rom();
    rom[0] = ent(50, 60, 1, 1);
    rom[1] = ent(50, 60, 1, 0);
    run_walk(1);
    chk("zl_busy", obs_busy, 7);
    chk("zl_lit", obs_lit, 0);
    chk("zl_end", {16'd0, x_out, y_out}, {16'd0, 8'd50, 8'd60});

    // no end marker: forced end at the last address
    for (int i = 0; i < NE; i++)
      rom[i] = ent($urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)), 1'b1);
    rom[7] = ent(mx, my, 1, 0);
    rom[8] = ent(200, 20, 1, 0);
    run_walk(1);
    chk("ne_done_addr", done_addr, NE - 1);
    chk("ne_done", obs_done, 1);

    // reset in the middle of a line
    clear_rom();
    rom[0] = ent(161, 147, 0, 1);
    rom[1] = ent(148, 162, 1, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("rl_in_draw", {31'd0, beam_on}, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rl_addr", {28'd0, rom_addr}, 0);
    chk("rl_xy", {16'd0, x_out, y_out}, 0);
    chk("rl_flags", {29'd0, beam_on, busy, done}, 0);
    mx = 0; my = 0;
    @(posedge clk); #1;
    chk("rl_idle", {31'd0, busy}, 0);
    run_walk(0);
    chk("rl_end", {16'd0, x_out, y_out}, {16'd0, 8'd148, 8'd162});

    // random lists; duplicated entries produce zero-length draws
    for (int w = 0; w < 10; w++) begin
      prevx = 0; prevy = 0;
      for (int i = 0; i < NE; i++) begin
        f = $urandom_range(0, 19);
        if ($urandom_range(0, 7) == 0) begin
          rom[i] = ent(prevx, prevy, 1, 0);
        end else begin
          prevx = $urandom_range(0, 255);
          prevy = $urandom_range(0, 255);
          if (f == 0)      rom[i] = ent(prevx, prevy, 0, 0);
          else if (f < 9)  rom[i] = ent(prevx, prevy, 0, 1);
          else if (f < 19) rom[i] = ent(prevx, prevy, 1, 0);
          else             rom[i] = ent(prevx, prevy, 1, 1);
        end
      end
      run_walk(1);
      chk("rnd_done", obs_done, 1);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/vector_walker.md
# vector_walker

Sequencer that reads a vector display list from a combinational shape ROM and turns it into a cycle-by-cycle beam trajectory for the X/Y DAC stage. Each ROM entry is an 18-bit word {x[7:0], y[7:0], draw, move}. The walker jumps the beam (blanked) on move entries and rasterises straight lines (beam lit, one DAC step per cycle) on draw entries. It is the reading end of every shape ROM in the NORAD-A vector pipeline and sits between those ROMs and the DAC output registers.

## Interface
- ADDRESSWIDTH, 4, ROM address width.
- DATAWIDTH, 18, ROM word width; fixed layout [17:10] x, [9:2] y, [1] draw, [0] move.
- NUM_ENTRIES, 16, number of addresses walked before forced end of list.
- SETTLE, 4, blanked dwell cycles after a move (1..15).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to walk the list from address 0.
- rom_addr  out  ADDRESSWIDTH  registered ROM address.
- rom_data  in  DATAWIDTH  ROM word; valid in the same cycle as rom_addr (zero-latency ROM).
- x_out  out  8  beam X position.
- y_out  out  8  beam Y position.
- beam_on  out  1  beam intensity enable.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at end of list.

## Operation
- States: IDLE, FETCH, SETTLE_S, DRAW, DONE.
- IDLE: when start=1, clear rom_addr to 0 and go to FETCH. start is ignored in every other state.
- FETCH: decode rom_data.
  - draw=0 and move=0 is the end marker: go to DONE.
  - move=1 (takes priority if draw is also 1): x_out/y_out take the target, beam_on=0, load the settle counter with SETTLE, go to SETTLE_S.
  - draw=1: load the line engine with target (x1,y1) and go to DRAW with beam_on=1. A zero-length draw (target equals current position) increments rom_addr and stays in FETCH.
- SETTLE_S: decrement the counter. At 1, increment rom_addr and go to FETCH.
- DRAW: integer Bresenham line engine.
  - dx=|x1-x|, dy=|y1-y|, sx/sy=±1. err is a 10-bit signed value initialised to dx-dy.
  - Each cycle, with e2=2·err:
    - if e2 > -dy: err -= dy, x += sx.
    - if e2 < dx: err += dx, y += sy.
  - Both updates use the pre-update err.
  - The line completes when the stepped position equals the target. On that cycle, increment rom_addr, go to FETCH, and keep beam_on=1 for that cycle.
  - A line takes exactly max(dx,dy) DRAW cycles. Arithmetic is 10-bit signed, so no wrap is possible for 8-bit coordinates.
- Address end: if rom_addr reaches NUM_ENTRIES-1 and that entry is consumed, go to DONE even without an end marker. rom_addr never wraps.
- DONE: beam_on=0, done=1 for one cycle, then IDLE. The position outputs hold their last value.
- beam_on is 1 only in DRAW (including the completion cycle).

## Timing
- Reset values: rom_addr=0, x_out=0, y_out=0, beam_on=0, busy=0, done=0, state IDLE, err=0, settle counter=0.
- rst overrides everything in the same edge, including mid-line or mid-settle. No pending work survives reset.
- Start to first FETCH: 1 cycle. A FETCH costs 1 cycle per entry.
- Move entry cost: 1 FETCH + SETTLE cycles. Position updates on the edge leaving FETCH.
- Draw entry cost: 1 FETCH + max(dx,dy) cycles. One position change per cycle, each axis by at most 1.
- The end marker at address k gives done k+... cycles after the last entry's work plus 1 FETCH + 1 DONE cycle. busy falls in the same cycle done rises.
- start in the DONE cycle is ignored. start in the first IDLE cycle afterwards is accepted.

## Structure
- Package vector_pkg:
  - vec_entry_t packed struct {x, y, draw, move}.
  - COORD_W=8.
  - walker_state_t enum.
  - This package is shared with all shape ROMs and the DAC stage.
- Sub-module line_stepper: Bresenham engine.
  - Inputs: load, x0/y0/x1/y1.
  - Outputs: x, y, last.
  - The walker owns the FSM, address counter and settle counter.

## Test plan
- Reset mid-line: assert rst while drawing (161,147)→(148,162). Next cycle all outputs are at reset values and state is IDLE; a fresh start restarts at rom_addr 0.
- Move then draw: entry0 {174,162,0,1}, entry1 {161,147,1,0}, entry2 end marker.
  - Beam at (174,162) blanked for 4 cycles.
  - Then 15 lit DRAW cycles ending at (161,147).
  - Then done; busy high for 1+4+1+15+1 cycles.
- Line shape: draw (0,0)→(10,3).
  - Exactly 10 steps; each step changes x by +1 and y by at most 1.
  - y increments 3 times; the final position is (10,3).
- Zero-length and both-flags entries:
  - Draw to the current position costs 1 cycle and beam_on stays 0.
  - An entry {50,60,1,1} is treated as a move: beam blanked, jumps to (50,60).
- End handling:
  - A list with no end marker and NUM_ENTRIES=16 gives done after address 15 with rom_addr=15 (no wrap).
  - start pulses while busy are ignored.
  - The walk restarts correctly on start the cycle after done.
